// File: rtl/prom_boot_ctl_if.sv
// prom_boot_ctl_if: fetch/store/control, boot ROM and program RAM bus for prom_boot_ctl.
// Rev 1.0
`default_nettype none

interface prom_boot_ctl_if #(
   parameter int AW = 14
);
   logic          if_req;
   logic [15:0]   if_adr;
   logic          if_rdy;
   logic [15:0]   if_dat;
   logic          wr_req;
   logic [15:0]   wr_adr;
   logic [15:0]   wr_dat;
   logic          wr_ack;
   logic          ctl_wr;
   logic [15:0]   ctl_dat;
   logic [6:0]    brom_adr;
   logic [15:0]   brom_dat;
   logic [AW-1:0] pmem_adr;
   logic [15:0]   pmem_din;
   logic          pmem_we;
   logic [15:0]   pmem_dout;
   logic          boot;
   logic          werr;
   logic [15:0]   wcnt;

   modport slave (
      input  if_req, if_adr, wr_req, wr_adr, wr_dat, ctl_wr, ctl_dat, brom_dat, pmem_dout,
      output if_rdy, if_dat, wr_ack, brom_adr, pmem_adr, pmem_din, pmem_we, boot, werr, wcnt
   );

   modport master (
      output if_req, if_adr, wr_req, wr_adr, wr_dat, ctl_wr, ctl_dat, brom_dat, pmem_dout,
      input  if_rdy, if_dat, wr_ack, brom_adr, pmem_adr, pmem_din, pmem_we, boot, werr, wcnt
   );
endinterface

`default_nettype wire

// File: rtl/prom_boot_ctl.sv
// prom_boot_ctl: serves fetches from boot ROM and lets the loader fill program RAM until a keyed
// control write locks the RAM and remaps fetches to it. Rev 1.0
`default_nettype none

module prom_boot_ctl #(
   parameter int          AW         = 14,
   parameter int          BOOT_WORDS = 128,
   parameter logic [15:0] KEY        = 16'ha55a
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   prom_boot_ctl_if.slave bus
);
   localparam logic [15:0] BOOT_LIM = 16'(BOOT_WORDS);

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_SWITCH = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          if_rdy_q, if_rdy_d;
   logic          ram_src_q, ram_src_d;
   logic [15:0]   if_dat_q, if_dat_d;
   logic          wr_ack_q;
   logic          werr_q, werr_d;
   logic [15:0]   wcnt_q, wcnt_d;
   logic [AW-1:0] pmem_adr_q, pmem_adr_d;
   logic [15:0]   pmem_din_q, pmem_din_d;
   logic          pmem_we;
   logic [6:0]    brom_adr;
   logic          in_rom;
   logic          unused_bits;

   assign in_rom      = {1'b0, bus.if_adr[15:1]} < BOOT_LIM;
   assign unused_bits = ^{bus.if_adr[0], bus.wr_adr[0], bus.wr_adr[15:AW+1]};

   always_comb begin
      state_d    = state_q;
      if_rdy_d   = 1'b0;
      ram_src_d  = 1'b0;
      if_dat_d   = if_dat_q;
      werr_d     = werr_q;
      wcnt_d     = wcnt_q;
      pmem_adr_d = pmem_adr_q;
      pmem_din_d = pmem_din_q;
      pmem_we    = 1'b0;
      brom_adr   = 7'd0;

      // RAM read data only exists for one cycle; latch it so if_dat holds afterwards.
      if (if_rdy_q && ram_src_q) begin
         if_dat_d = bus.pmem_dout;
      end

      unique case (state_q)
         ST_BOOT: begin
            brom_adr = bus.if_adr[7:1];
            if (bus.if_req) begin
               if_rdy_d = 1'b1;
               if_dat_d = in_rom ? bus.brom_dat : 16'hffff;
            end
            if (bus.wr_req) begin
               pmem_we    = 1'b1;
               pmem_adr_d = bus.wr_adr[AW:1];
               pmem_din_d = bus.wr_dat;
               if (wcnt_q != 16'hffff) begin
                  wcnt_d = wcnt_q + 16'd1;
               end
            end
            if (bus.ctl_wr && (bus.ctl_dat == KEY)) begin
               state_d = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            pmem_adr_d = bus.if_adr[AW:1];
            if (bus.if_req) begin
               if_rdy_d  = 1'b1;
               ram_src_d = 1'b1;
            end
            if (bus.wr_req) begin
               werr_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         if_rdy_q   <= 1'b0;
         ram_src_q  <= 1'b0;
         if_dat_q   <= 16'h0000;
         wr_ack_q   <= 1'b0;
         werr_q     <= 1'b0;
         wcnt_q     <= 16'h0000;
         pmem_adr_q <= '0;
         pmem_din_q <= 16'h0000;
      end else begin
         state_q    <= state_d;
         if_rdy_q   <= if_rdy_d;
         ram_src_q  <= ram_src_d;
         if_dat_q   <= if_dat_d;
         wr_ack_q   <= bus.wr_req;
         werr_q     <= werr_d;
         wcnt_q     <= wcnt_d;
         pmem_adr_q <= pmem_adr_d;
         pmem_din_q <= pmem_din_d;
      end
   end

   assign bus.if_rdy   = if_rdy_q;
   assign bus.if_dat   = (if_rdy_q && ram_src_q) ? bus.pmem_dout : if_dat_q;
   assign bus.wr_ack   = wr_ack_q;
   assign bus.brom_adr = brom_adr;
   assign bus.pmem_adr = pmem_adr_d;
   assign bus.pmem_din = pmem_din_d;
   assign bus.pmem_we  = pmem_we;
   assign bus.boot     = (state_q == ST_BOOT);
   assign bus.werr     = werr_q;
   assign bus.wcnt     = wcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prom_boot_ctl.sv
// tb_prom_boot_ctl: directed and randomized checks of prom_boot_ctl against a word-level model.
// Rev 1.0
`default_nettype none

module tb_prom_boot_ctl;
   localparam int          AW  = 14;
   localparam logic [15:0] KEY = 16'ha55a;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prom_boot_ctl_if #(.AW(AW)) bus ();

   prom_boot_ctl #(.AW(AW), .BOOT_WORDS(128), .KEY(KEY)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   logic [15:0] rom [0:127];
   logic [15:0] ram [0:(1<<AW)-1];

   assign bus.brom_dat = rom[bus.brom_adr];

   always @(posedge clk) begin
      if (bus.pmem_we) ram[bus.pmem_adr] <= bus.pmem_din;
      bus.pmem_dout <= ram[bus.pmem_adr];
   end

   // Reference view: RAM contents keyed by word index, plus the list of loaded byte addresses.
   logic [15:0] exp_ram [int];
   logic [15:0] wq [$];
   int exp_wcnt = 0;
   int n_pass   = 0;
   int n_chk    = 0;

   function automatic logic [15:0] boot_fetch(input logic [15:0] a);
      int w;
      w = int'(a) / 2;
      return (w < 128) ? rom[w] : 16'hffff;
   endfunction

   function automatic int ram_idx(input logic [15:0] a);
      return (int'(a) / 2) % (1 << AW);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive(input logic fr, input logic [15:0] fa, input logic wr,
                        input logic [15:0] wa, input logic [15:0] wd,
                        input logic cw, input logic [15:0] cd);
      @(negedge clk);
      bus.if_req  = fr;
      bus.if_adr  = fa;
      bus.wr_req  = wr;
      bus.wr_adr  = wa;
      bus.wr_dat  = wd;
      bus.ctl_wr  = cw;
      bus.ctl_dat = cd;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.if_req = 1'b0; bus.if_adr = 16'h0; bus.wr_req = 1'b0; bus.wr_adr = 16'h0;
      bus.wr_dat = 16'h0; bus.ctl_wr = 1'b0; bus.ctl_dat = 16'h0;
      for (int i = 0; i < 128; i++) rom[i] = 16'($urandom);
      rom[0]   = 16'h0801;
      rom[115] = 16'h0002;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_rdy", bus.if_rdy, 0);
      chk("rst_if_dat", bus.if_dat, 0);
      chk("rst_wr_ack", bus.wr_ack, 0);
      chk("rst_boot", bus.boot, 1);
      chk("rst_werr", bus.werr, 0);
      chk("rst_wcnt", bus.wcnt, 0);
      chk("rst_pmem_we", bus.pmem_we, 0);
      chk("rst_brom_adr", bus.brom_adr, 0);
      chk("rst_pmem_adr", bus.pmem_adr, 0);
      chk("rst_pmem_din", bus.pmem_din, 0);
      @(negedge clk) rst_n = 1'b1;

      // Boot ROM fetches, including one beyond the ROM
      drive(1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("rom0_rdy", bus.if_rdy, 1); chk("rom0_dat", bus.if_dat, 16'h0801);
      drive(1'b1, 16'h00e6, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("rome6_rdy", bus.if_rdy, 1); chk("rome6_dat", bus.if_dat, 16'h0002);
      drive(1'b1, 16'h0100, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("rom100_rdy", bus.if_rdy, 1); chk("rom100_dat", bus.if_dat, 16'hffff);
      idle(); tick();
      chk("rom_idle_rdy", bus.if_rdy, 0); chk("rom_hold_dat", bus.if_dat, 16'hffff);

      // Back-to-back BOOT writes with interleaved fetches
      drive(1'b1, 16'h0004, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'h0); #1;
      chk("w0_we", bus.pmem_we, 1); chk("w0_adr", bus.pmem_adr, 0); chk("w0_din", bus.pmem_din, 16'h1234);
      tick();
      chk("w0_ack", bus.wr_ack, 1); chk("w0_frdy", bus.if_rdy, 1); chk("w0_fdat", bus.if_dat, boot_fetch(16'h0004));
      drive(1'b1, 16'h0006, 1'b1, 16'h0002, 16'h5678, 1'b0, 16'h0); #1;
      chk("w1_we", bus.pmem_we, 1); chk("w1_adr", bus.pmem_adr, 1); chk("w1_din", bus.pmem_din, 16'h5678);
      tick();
      chk("w1_ack", bus.wr_ack, 1); chk("w1_fdat", bus.if_dat, boot_fetch(16'h0006));
      exp_ram[0] = 16'h1234; exp_ram[1] = 16'h5678; exp_wcnt = 2;
      idle(); #1;
      chk("widle_we", bus.pmem_we, 0); chk("widle_adr_hold", bus.pmem_adr, 1);
      tick();
      chk("widle_ack", bus.wr_ack, 0); chk("wcnt2", bus.wcnt, 2);

      // Randomized BOOT traffic
      for (int i = 0; i < 24; i++) begin
         logic fr, wr;
         logic [15:0] fa, wa, wd;
         fr = 1'($urandom_range(0, 1));
         fa = 16'($urandom_range(0, 511));
         wr = 1'($urandom_range(0, 1));
         wa = 16'($urandom) | 16'h0004;
         wd = 16'($urandom);
         drive(fr, fa, wr, wa, wd, 1'b0, 16'h0); tick();
         chk("rb_rdy", bus.if_rdy, 32'(fr));
         if (fr) chk("rb_dat", bus.if_dat, boot_fetch(fa));
         chk("rb_ack", bus.wr_ack, 32'(wr));
         if (wr) begin
            exp_ram[ram_idx(wa)] = wd;
            wq.push_back(wa);
            exp_wcnt++;
         end
      end
      idle(); tick();
      chk("rb_wcnt", bus.wcnt, exp_wcnt);
      chk("rb_werr", bus.werr, 0);

      // Wrong key ignored, right key enters SWITCH then RUN
      drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0000); tick();
      chk("badkey_boot", bus.boot, 1);
      drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, KEY); tick();
      chk("key_boot", bus.boot, 0);
      drive(1'b1, 16'h0002, 1'b1, 16'h0008, 16'hbeef, 1'b0, 16'h0); #1;
      chk("sw_we", bus.pmem_we, 0);
      tick();
      chk("sw_no_rdy", bus.if_rdy, 0); chk("sw_ack", bus.wr_ack, 1); chk("sw_werr", bus.werr, 0);
      drive(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); #1;
      chk("run_adr", bus.pmem_adr, 1);
      tick();
      chk("run_rdy", bus.if_rdy, 1); chk("run_dat", bus.if_dat, 16'h5678);
      idle(); tick();
      chk("run_idle_rdy", bus.if_rdy, 0); chk("run_hold_dat", bus.if_dat, 16'h5678);

      // Write attempted in RUN
      drive(1'b0, 16'h0, 1'b1, 16'h0000, 16'hdead, 1'b0, 16'h0); #1;
      chk("runw_we", bus.pmem_we, 0);
      tick();
      chk("runw_ack", bus.wr_ack, 1); chk("runw_werr", bus.werr, 1);
      drive(1'b1, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("runf0_dat", bus.if_dat, 16'h1234);

      // Randomized back-to-back RUN fetches of loaded words, some through the wrapped alias
      for (int i = 0; i < 16; i++) begin
         logic [15:0] a;
         a = wq[$urandom_range(0, wq.size() - 1)];
         if ($urandom_range(0, 1) == 1) a = a ^ 16'h8000;
         drive(1'b1, a, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
         chk("rr_rdy", bus.if_rdy, 1);
         chk("rr_dat", bus.if_dat, exp_ram[ram_idx(a)]);
      end
      idle(); tick();
      chk("run_wcnt", bus.wcnt, exp_wcnt); chk("run_werr_sticky", bus.werr, 1); chk("run_boot", bus.boot, 0);

      // Reset during RUN aborts the pending handshakes
      drive(1'b1, 16'h0002, 1'b1, 16'h0000, 16'hdead, 1'b0, 16'h0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_rdy", bus.if_rdy, 0); chk("mrst_ack", bus.wr_ack, 0);
      idle(); tick();
      chk("mrst_if_dat", bus.if_dat, 0); chk("mrst_boot", bus.boot, 1); chk("mrst_werr", bus.werr, 0);
      chk("mrst_wcnt", bus.wcnt, 0); chk("mrst_we", bus.pmem_we, 0); chk("mrst_adr", bus.pmem_adr, 0);
      chk("mrst_din", bus.pmem_din, 0); chk("mrst_brom", bus.brom_adr, 0);
      @(negedge clk) rst_n = 1'b1;
      drive(1'b1, 16'h00e6, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("postrst_rdy", bus.if_rdy, 1); chk("postrst_dat", bus.if_dat, 16'h0002);

      // Key write together with a write and a fetch
      drive(1'b1, 16'h0000, 1'b1, 16'h0010, 16'hbeef, 1'b1, KEY); #1;
      chk("kw_we", bus.pmem_we, 1);
      tick();
      chk("kw_boot", bus.boot, 0); chk("kw_ack", bus.wr_ack, 1); chk("kw_wcnt", bus.wcnt, 1);
      chk("kw_frdy", bus.if_rdy, 1); chk("kw_fdat", bus.if_dat, 16'h0801);
      idle(); tick();
      drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0); tick();
      chk("kw_run_rdy", bus.if_rdy, 1); chk("kw_run_dat", bus.if_dat, 16'hbeef);
      idle(); tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
